// File: rtl/wb_regfile.sv
// RV32I writeback stage: result select, 32x32 integer register file with two async read ports, commit counter.
// Optional write-first bypass on the read ports when WB_REGFILE_BYPASS_EN is defined.
module wb_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [4:0]      RdW,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ResultW,
  output logic [31:0]     WbCount
);

  logic [XLEN-1:0] regs [NREGS];
  logic [31:0]     wbCount;
  logic            wrHit;

  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

  assign wrHit = rst_n && RegWriteW && (RdW != 5'd0);

  // x0 is never written; its slot only sees the reset clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i[4:0]] <= '0;
      wbCount <= '0;
    end else if (RegWriteW) begin
      wbCount <= wbCount + 32'd1;
      if (RdW != 5'd0) regs[RdW] <= ResultW;
    end
  end

  always_comb begin
    RD1D = (Rs1D == 5'd0) ? '0 : regs[Rs1D];
    RD2D = (Rs2D == 5'd0) ? '0 : regs[Rs2D];
`ifdef WB_REGFILE_BYPASS_EN
    if (wrHit && (RdW == Rs1D)) RD1D = ResultW;
    if (wrHit && (RdW == Rs2D)) RD2D = ResultW;
`endif
  end

  assign WbCount = wbCount;

endmodule
